stage3_mcfu_sequencer: RTL and testbench
========================================

Name: stage3_mcfu_sequencer

Overview:
Sequences multi-cycle functional units (RV32M divider/multiplier, future FUs) for the stage3 execute stage. Issues a one-cycle start to the selected unit and generates the execute-busy stall until the result is ready. Holds the result stable while the EX/MEM register is stalled, and discards in-flight results after a flush. Sits between the control-unit FU select and the FU output mux that feeds the EX/MEM pipeline register.

Parameters:
NUM_FU, 2, number of multi-cycle FUs attached (index 0 = RV32M)
SEL_W, $clog2(NUM_FU) (min 1), width of FU select
WDOG_CYCLES, 64, watchdog limit in cycles (used only with optional feature)

Ports:
CLK  in  1  clock
nRST  in  1  reset, synchronous, active-low
issue_valid  in  1  EX instruction is valid and needs a multi-cycle FU (already gated by mem_use_stall)
issue_sel  in  SEL_W  FU index for this instruction
flush  in  1  ex_mem_flush from hazard unit; kills current EX instruction
pipe_stall  in  1  ex_mem_stall; EX/MEM register not accepting
fu_start  out  NUM_FU  one-hot start pulse
fu_done  in  NUM_FU  per-FU done pulse/level
fu_result  in  NUM_FU*32  per-FU result, FU i at [32*i+31:32*i]
ex_busy  out  1  stall request to hazard unit
result_valid  out  1  result_data valid for the EX instruction
result_data  out  32  held FU result
fu_timeout  out  1  watchdog event (optional feature; tied 0 otherwise)

Behaviour:
- Synchronous reset (nRST=0 at posedge): state=IDLE, sel_q=0, result_q=0, all outputs 0.
- States: IDLE, BUSY, HOLD, DRAIN.
- IDLE: if issue_valid && !flush: fu_start[issue_sel]=1 (combinational, exactly one cycle), capture sel_q=issue_sel, next=BUSY. ex_busy=issue_valid && !flush.
- BUSY: ex_busy=1. On fu_done[sel_q]: result_q<=fu_result[sel_q], next=HOLD. done from other FUs ignored. fu_done[sel_q] in the same cycle as BUSY entry is impossible by FU contract; no check.
- HOLD: ex_busy=0, result_valid=1, result_data=result_q. Stay while pipe_stall. No restart even though issue_valid stays high. If !pipe_stall, next=IDLE.
- DRAIN: in-flight op was flushed. Wait for fu_done[sel_q], discard result, next=IDLE. ex_busy=issue_valid (a new instruction waits). No start issued in DRAIN.
- Flush priority: flush in IDLE -> no start; in BUSY -> DRAIN (same cycle as done -> IDLE, result discarded); in HOLD -> IDLE; in DRAIN -> stay.
- Latency: start at cycle N, FU done at cycle N+k, result_valid at N+k+1, earliest next start at N+k+2.
- issue_sel >= NUM_FU: no start, stay IDLE, ex_busy=0 (control unit guarantees this does not occur).
- result_data=0 whenever result_valid=0.

Optional Feature:
MCFU_WATCHDOG_EN: counter cleared on BUSY/DRAIN entry, increments each cycle in BUSY/DRAIN. On reaching WDOG_CYCLES: fu_timeout=1 for one cycle; BUSY -> HOLD with result_q=32'hFFFF_FFFF; DRAIN -> IDLE. Without the macro: no counter, fu_timeout tied 0, BUSY/DRAIN wait indefinitely.

Decomposition:
- stage3_types_pkg: mcfu_state_t enum (IDLE, BUSY, HOLD, DRAIN), MCFU_TIMEOUT_RESULT constant.
- Watchdog as sub-module stage3_mcfu_watchdog (clear, count_en, expired), instantiated only under the macro.

Test Plan:
- Issue sel=0; FU done 4 cycles after start, result 0x0000_002A -> fu_start=01 one cycle; ex_busy=1 for 5 cycles; result_valid=1 with 0x2A on cycle 6; ex_busy=0.
- As above with pipe_stall=1 for 3 cycles in HOLD -> result_valid/result_data 0x2A held 4 cycles; no second fu_start.
- Flush 2 cycles after start; new issue_valid sel=1 next cycle; FU0 done at +5 -> DRAIN, ex_busy=1 until done, result discarded; fu_start=10 the cycle after FU0 done.
- flush and fu_done[sel_q] in the same cycle in BUSY -> IDLE; result_valid stays 0.
- fu_done[1] pulses while sel_q=0 -> ignored; state stays BUSY.
- With MCFU_WATCHDOG_EN and WDOG_CYCLES=8, FU never done -> fu_timeout pulse 8 cycles after start; result 0xFFFF_FFFF in HOLD.

Source files
------------

// File: rtl/stage3_types_pkg.sv
// stage3_types_pkg: shared state encoding and constants for the stage3 multi-cycle FU sequencer
package stage3_types_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} mcfu_state_t;
  localparam logic [31:0] MCFU_TIMEOUT_RESULT = 32'hFFFF_FFFF;
endpackage

// File: rtl/stage3_mcfu_watchdog.sv
// stage3_mcfu_watchdog: cycle counter that flags when a waiting FU has taken WDOG_CYCLES cycles
module stage3_mcfu_watchdog #(
  parameter int WDOG_CYCLES = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // restart on each new wait, otherwise count every waiting cycle
  always_comb cnt_d = clear ? '0 : count_en ? cnt_q + 1'b1 : cnt_q;
  // the cycle that completes WDOG_CYCLES waiting cycles is the expiry cycle
  assign expired = count_en && (cnt_q == CW'(WDOG_CYCLES - 1));
  // counter register
  always_ff @(posedge CLK) begin
    if (!nRST) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/stage3_mcfu_sequencer.sv
// stage3_mcfu_sequencer: start/stall/hold/drain sequencing of multi-cycle FUs (optional MCFU_WATCHDOG_EN)
module stage3_mcfu_sequencer
  import stage3_types_pkg::*;
#(
  parameter int NUM_FU      = 2,
  parameter int SEL_W       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 issue_valid,
  input  logic [SEL_W-1:0]     issue_sel,
  input  logic                 flush,
  input  logic                 pipe_stall,
  output logic [NUM_FU-1:0]    fu_start,
  input  logic [NUM_FU-1:0]    fu_done,
  input  logic [NUM_FU*32-1:0] fu_result,
  output logic                 ex_busy,
  output logic                 result_valid,
  output logic [31:0]          result_data,
  output logic                 fu_timeout
);
  mcfu_state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [31:0] result_q, result_d;
  logic start_ok, done_sel, wd_exp, wd_hit;

  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 1");
  end

  assign start_ok = nRST && issue_valid && !flush && (int'(issue_sel) < NUM_FU);
  assign done_sel = fu_done[sel_q];
  assign wd_hit = wd_exp && !done_sel;
  assign fu_timeout = wd_hit;
  assign result_data = result_valid ? result_q : '0;

`ifdef MCFU_WATCHDOG_EN
  stage3_mcfu_watchdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   ((state_d == BUSY || state_d == DRAIN) && state_d != state_q),
    .count_en(state_q == BUSY || state_q == DRAIN),
    .expired (wd_exp)
  );
`else
  assign wd_exp = 1'b0;
`endif

  // next state, start pulse, stall request and result capture
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    result_d = result_q;
    fu_start = '0;
    ex_busy = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        ex_busy = start_ok;
        if (start_ok) begin
          fu_start = NUM_FU'(1) << issue_sel;
          sel_d = issue_sel;
          state_d = BUSY;
        end
      end
      BUSY: begin
        ex_busy = 1'b1;
        if (flush) state_d = (done_sel || wd_hit) ? IDLE : DRAIN;
        else if (done_sel || wd_hit) begin
          result_d = done_sel ? fu_result[32*int'(sel_q) +: 32] : MCFU_TIMEOUT_RESULT;
          state_d = HOLD;
        end
      end
      HOLD: begin
        result_valid = 1'b1;
        state_d = (flush || !pipe_stall) ? IDLE : HOLD;
      end
      DRAIN: begin
        ex_busy = issue_valid;
        state_d = (done_sel || wd_hit) ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, selected FU and held result registers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      sel_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_stage3_mcfu_sequencer.sv
// tb_stage3_mcfu_sequencer: transaction-level self-checking bench for stage3_mcfu_sequencer
module tb_stage3_mcfu_sequencer;
  localparam int WD = 64;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        issue_valid;
  logic [0:0]  issue_sel;
  logic        flush;
  logic        pipe_stall;
  logic [1:0]  fu_start;
  logic [1:0]  fu_done;
  logic [63:0] fu_result;
  logic        ex_busy;
  logic        result_valid;
  logic [31:0] result_data;
  logic        fu_timeout;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int sel;
    int k;
    int stall;
    int flush_at;
    bit hold_flush;
    bit drain_iv;
    int gap;
    bit gap_flush;
    logic [31:0] res;
  } txn_t;
  txn_t txq[$];

  always #5 CLK = ~CLK;

  stage3_mcfu_sequencer dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .issue_valid (issue_valid),
    .issue_sel   (issue_sel),
    .flush       (flush),
    .pipe_stall  (pipe_stall),
    .fu_start    (fu_start),
    .fu_done     (fu_done),
    .fu_result   (fu_result),
    .ex_busy     (ex_busy),
    .result_valid(result_valid),
    .result_data (result_data),
    .fu_timeout  (fu_timeout)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_sel = 1'b0;
    flush = 1'b0;
    pipe_stall = 1'b0;
    fu_done = 2'b00;
    fu_result = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    repeat (3) tick();
    @(negedge CLK);
    checks++;
    if ({fu_start, ex_busy, result_valid, fu_timeout} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {fu_start, ex_busy, result_valid, fu_timeout});
    end
    checks++;
    if (result_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=00000000", result_data);
    end
    tick();
    nRST = 1'b1;
    issue_valid = 1'b1;
    @(negedge CLK);
    checks++;
    if (fu_start !== 2'b01) begin
      failures++;
      $display("FAIL reset_then_start got=%b exp=01", fu_start);
    end
    tick();
    issue_valid = 1'b0;
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    fu_done = 2'b01;
    fu_result = {32'h0, 32'h0000_0123};
    @(negedge CLK);
    checks++;
    if (ex_busy !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset_busy got=%b exp=0", ex_busy);
    end
    tick();
    fu_done = 2'b00;
    @(negedge CLK);
    checks++;
    if (result_valid !== 1'b0 || result_data !== 32'h0) begin
      failures++;
      $display("FAIL midop_reset_result got=%b/%h exp=0/00000000", result_valid, result_data);
    end
  endtask

  task automatic build_directed();
    txn_t t;
    t = '{sel:0, k:4, stall:0, flush_at:0, hold_flush:0, drain_iv:0, gap:0, gap_flush:0, res:32'h0000_002A};
    txq.push_back(t);
    t.stall = 3;
    txq.push_back(t);
    t = '{sel:0, k:5, stall:0, flush_at:2, hold_flush:0, drain_iv:1, gap:0, gap_flush:0, res:32'hDEAD_0001};
    txq.push_back(t);
    t = '{sel:1, k:3, stall:0, flush_at:0, hold_flush:0, drain_iv:0, gap:0, gap_flush:0, res:32'h1234_5678};
    txq.push_back(t);
    t = '{sel:1, k:3, stall:0, flush_at:3, hold_flush:0, drain_iv:0, gap:1, gap_flush:1, res:32'hBAD0_BAD0};
    txq.push_back(t);
    t = '{sel:0, k:2, stall:2, flush_at:0, hold_flush:1, drain_iv:0, gap:2, gap_flush:0, res:32'h0F0F_F0F0};
    txq.push_back(t);
  endtask

  task automatic build_random(input int n);
    txn_t t;
    for (int i = 0; i < n; i++) begin
      t.sel = int'($urandom_range(0, 1));
      t.k = int'($urandom_range(1, 6));
      t.stall = int'($urandom_range(0, 3));
      t.flush_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, t.k)) : 0;
      t.hold_flush = ($urandom_range(0, 4) == 0);
      t.drain_iv = 1'($urandom);
      t.gap = int'($urandom_range(0, 2));
      t.gap_flush = 1'($urandom);
      t.res = $urandom;
      txq.push_back(t);
    end
  endtask

  // each transaction: start at t=0, FU done at t=k, result held t=k+1 .. end unless flushed
  task automatic test_txn_stream();
    txn_t c, n;
    bit has_next, fl, hf, in_drain;
    int len;
    logic [1:0] exp_start;
    logic exp_busy, exp_rv;
    logic [31:0] exp_rd;
    for (int i = 0; i < txq.size(); i++) begin
      c = txq[i];
      has_next = (i + 1 < txq.size());
      n = has_next ? txq[i+1] : c;
      fl = c.flush_at > 0;
      hf = !fl && c.hold_flush && c.stall > 0;
      len = fl ? c.k + 1 : (hf ? c.k + 2 : c.k + 2 + c.stall);
      for (int g = 0; g < c.gap; g++) begin
        idle_inputs();
        issue_valid = c.gap_flush;
        issue_sel = 1'(c.sel);
        flush = c.gap_flush;
        @(negedge CLK);
        checks++;
        if ({fu_start, ex_busy, result_valid, fu_timeout} !== 5'b0 || result_data !== 32'h0) begin
          failures++;
          $display("FAIL gap txn%0d g%0d got=%b/%h exp=00000/00000000", i, g,
                   {fu_start, ex_busy, result_valid, fu_timeout}, result_data);
        end
        tick();
      end
      for (int t = 0; t < len; t++) begin
        in_drain = fl && t > c.flush_at;
        issue_valid = in_drain ? (c.drain_iv && has_next) : 1'b1;
        issue_sel = in_drain ? 1'(n.sel) : 1'(c.sel);
        flush = (t == c.flush_at && fl) || (hf && t == c.k + 1);
        pipe_stall = (t > c.k) ? (t <= c.k + c.stall) : 1'($urandom);
        fu_done = 2'b00;
        if (t == c.k) fu_done[c.sel] = 1'b1;
        if (t >= 1 && t < c.k) fu_done[1-c.sel] = 1'b1;
        fu_result = {$urandom, $urandom};
        if (t == c.k) fu_result[32*c.sel +: 32] = c.res;
        exp_start = (t == 0) ? 2'(1 << c.sel) : 2'b00;
        exp_busy = (t <= c.k) ? (in_drain ? issue_valid : 1'b1) : 1'b0;
        exp_rv = !fl && t > c.k;
        exp_rd = exp_rv ? c.res : 32'h0;
        @(negedge CLK);
        checks++;
        if (fu_start !== exp_start) begin
          failures++;
          $display("FAIL fu_start txn%0d t%0d got=%b exp=%b", i, t, fu_start, exp_start);
        end
        checks++;
        if (ex_busy !== exp_busy) begin
          failures++;
          $display("FAIL ex_busy txn%0d t%0d got=%b exp=%b", i, t, ex_busy, exp_busy);
        end
        checks++;
        if (result_valid !== exp_rv) begin
          failures++;
          $display("FAIL result_valid txn%0d t%0d got=%b exp=%b", i, t, result_valid, exp_rv);
        end
        checks++;
        if (result_data !== exp_rd) begin
          failures++;
          $display("FAIL result_data txn%0d t%0d got=%h exp=%h", i, t, result_data, exp_rd);
        end
        checks++;
        if (fu_timeout !== 1'b0) begin
          failures++;
          $display("FAIL fu_timeout txn%0d t%0d got=%b exp=0", i, t, fu_timeout);
        end
        tick();
      end
    end
    idle_inputs();
  endtask

`ifdef MCFU_WATCHDOG_EN
  task automatic test_watchdog();
    idle_inputs();
    for (int t = 0; t <= WD + 1; t++) begin
      issue_valid = (t == 0);
      fu_done = 2'b00;
      @(negedge CLK);
      checks++;
      if (fu_timeout !== (t == WD)) begin
        failures++;
        $display("FAIL wdog_timeout t%0d got=%b exp=%b", t, fu_timeout, (t == WD));
      end
      checks++;
      if (result_valid !== (t == WD + 1) || result_data !== ((t == WD + 1) ? 32'hFFFF_FFFF : 32'h0)) begin
        failures++;
        $display("FAIL wdog_result t%0d got=%b/%h", t, result_valid, result_data);
      end
      tick();
    end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    tick();
    idle_inputs();
    build_directed();
    build_random(40);
    test_txn_stream();
`ifdef MCFU_WATCHDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
